// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_pkg : shared MDU operation encodings and latency constants. Rev 1.0
// ---------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;
  localparam int unsigned CNT_W    = 4;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_e.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_e : E-stage multiply/divide unit with HI/LO and fixed-latency busy. Rev 1.0
// ---------------------------------------------------------------------------
module mdu_e
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic        load_pending;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, sgn_div;
  logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur, q_res, r_res;

  assign busy         = (cnt_q != '0);
  assign load_pending = start & ~busy & is_muldiv(md_op);
  assign md_stall     = (md_op != MD_NONE) & (busy | load_pending);
  assign hi           = hi_q;
  assign lo           = lo_q;

  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI)      md_out = hi_q;
    else if (md_op == MD_MFLO) md_out = lo_q;
  end

  // Signed division runs on magnitudes so INT_MIN / -1 cannot overflow the divider.
  always_comb begin
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    sgn_div = (op_q == MD_DIV);
    a_neg   = sgn_div & a_q[31];
    b_neg   = sgn_div & b_q[31];
    a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
    dvd     = a_mag;
    dvs     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = dvd / dvs;
    ur      = dvd % dvs;
    q_res   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    r_res   = a_neg ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        case (op_q)
          MD_MULT:  {hi_d, lo_d} = prod_s;
          MD_MULTU: {hi_d, lo_d} = prod_u;
          MD_DIV, MD_DIVU: begin
            if (b_q != 32'd0) begin
              lo_d = q_res;
              hi_d = r_res;
            end
          end
          default: ;
        endcase
      end
    end else if (start) begin
      if (load_pending) begin
        op_d  = md_op;
        a_d   = rs_data;
        b_d   = rt_data;
        cnt_d = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
      end else if (md_op == MD_MTHI) begin
        hi_d = rs_data;
      end else if (md_op == MD_MTLO) begin
        lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_e.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdu_e : directed and randomized self-checking bench for mdu_e. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_data, rt_data;
  logic        busy, md_stall;
  logic [31:0] md_out, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_e dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .start   (start),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .md_stall(md_stall),
    .md_out  (md_out),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed at issue, committed after the latency elapses.
  int              m_cnt;
  logic [31:0]     m_hi, m_lo, p_hi, p_lo;
  bit              p_we;
  longint          sp;
  longint unsigned up;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_hi = 0; m_lo = 0; p_we = 0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && p_we) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      case (md_op)
        4'd1: begin
          sp = longint'(int'(rs_data)) * longint'(int'(rt_data));
          {p_hi, p_lo} = sp; p_we = 1; m_cnt = 5;
        end
        4'd2: begin
          up = longint'(rs_data) * longint'(rt_data);
          {p_hi, p_lo} = up; p_we = 1; m_cnt = 5;
        end
        4'd3: begin
          p_we = (rt_data != 0); m_cnt = 10;
          if (p_we) begin
            p_lo = int'(rs_data) / int'(rt_data);
            p_hi = int'(rs_data) % int'(rt_data);
          end
        end
        4'd4: begin
          p_we = (rt_data != 0); m_cnt = 10;
          if (p_we) begin
            p_lo = rs_data / rt_data;
            p_hi = rs_data % rt_data;
          end
        end
        4'd7: m_hi = rs_data;
        4'd8: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_out;
    e_stall = (md_op != 0) && ((m_cnt != 0) || (start && md_op >= 1 && md_op <= 4));
    e_out   = (md_op == 4'd5) ? m_hi : (md_op == 4'd6) ? m_lo : 32'd0;
    check("cyc_busy",  {31'd0, busy},     {31'd0, m_cnt != 0});
    check("cyc_hi",    hi,                m_hi);
    check("cyc_lo",    lo,                m_lo);
    check("cyc_stall", {31'd0, md_stall}, {31'd0, e_stall});
    check("cyc_mdout", md_out,            e_out);
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; rs_data = a; rt_data = b; start = 1'b1;
    #1;
    if (op >= 1 && op <= 4) check("stall_on_start", {31'd0, md_stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, stalls, sel;
    reset = 1'b0; start = 1'b0; md_op = 4'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    check("rst_hi",    hi,                32'd0);
    check("rst_lo",    lo,                32'd0);
    check("rst_mdout", md_out,            32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(4'd7, 32'h11, 32'd0);
    check("mthi_hi", hi, 32'h11);
    issue(4'd8, 32'h22, 32'd0);
    check("mtlo_lo", lo, 32'h22);
    issue(4'd4, 32'd5, 32'd0);
    wait_idle(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    issue(4'd1, 32'h1234, 32'h10);
    md_op = 4'd6;
    n = 0; stalls = 0;
    while (busy && n < 20) begin
      n++;
      if (md_stall) stalls++;
      @(posedge clk); #1;
    end
    check("stall_cycles", n, 32'd5);
    check("stall_count", stalls, 32'd5);
    check("stall_mdout", md_out, 32'h0001_2340);
    md_op = 4'd0;

    issue(4'd7, 32'h55, 32'd0);
    issue(4'd3, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi",   hi,            32'd0);
    check("midrst_lo",   lo,            32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_hi",   hi,            32'd0);
    check("postrst_lo",   lo,            32'd0);

    repeat (600) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      md_op = 4'($urandom_range(0, 8));
      sel   = $urandom_range(0, 5);
      rs_data = (sel == 1) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      rt_data = (sel == 0) ? 32'd0 : (sel <= 2) ? 32'($urandom_range(0, 16)) - 32'd8 : $urandom;
      if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) rt_data = 32'd1;
    end
    start = 1'b0; md_op = 4'd0;
    repeat (15) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
